// File: rtl/alu_result_capture.sv
// ALU result capture: derives Z/N/C/V per transaction and buffers
// result+flags in a FWFT FIFO; optional checker via ALU_CAPTURE_CHECK_EN.
//
// Ports: clock, reset_n (async low), clear (sync flush)
//   in_valid/in_ready, in_op, in_a, in_b, in_result : capture side
//   out_valid/out_ready, out_result, out_flags      : reader side
//   count, mismatch, mismatch_count                 : status
module alu_result_capture #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_op,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  input  logic [WIDTH-1:0]       in_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_result,
  output logic [3:0]             out_flags,
  output logic [$clog2(DEPTH):0] count,
  output logic                   mismatch,
  output logic [7:0]             mismatch_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          is_add;
  logic          is_sub;
  logic          a_msb;
  logic          b_msb;
  logic          r_msb;
  logic          c_flag;
  logic          v_flag;
  logic [3:0]    flags;

  assign in_ready  = count < CW'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign is_add = in_op == OP_ADD;
  assign is_sub = in_op == OP_SUB;
  assign a_msb  = in_a[WIDTH-1];
  assign b_msb  = in_b[WIDTH-1];
  assign r_msb  = in_result[WIDTH-1];

  // a+b carries out exactly when a exceeds the complement of b
  always_comb begin
    c_flag = 1'b0;
    v_flag = 1'b0;
    unique case (1'b1)
      is_add: begin
        c_flag = in_a > ~in_b;
        v_flag = (a_msb == b_msb) && (r_msb != a_msb);
      end
      is_sub: begin
        c_flag = in_a < in_b;
        v_flag = (a_msb != b_msb) && (r_msb != a_msb);
      end
      default: ;
    endcase
  end

  assign flags = {in_result == '0, r_msb, c_flag, v_flag};

  // storage is intentionally not reset
  always_ff @(posedge clock) begin
    if (push && !clear) begin
      mem[wr_ptr] <= '{result: in_result, flags: flags};
    end
  end

  assign head       = mem[rd_ptr];
  assign out_result = head.result;
  assign out_flags  = head.flags;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef ALU_CAPTURE_CHECK_EN
  logic [WIDTH-1:0] expected;
  logic             bad;

  assign expected = is_add ? in_a + in_b : in_a - in_b;
  assign bad = push && (is_add || is_sub) && (in_result != expected);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mismatch       <= 1'b0;
      mismatch_count <= '0;
    end else if (clear) begin
      mismatch       <= 1'b0;
      mismatch_count <= '0;
    end else if (bad) begin
      mismatch <= 1'b1;
      if (mismatch_count != 8'hFF) begin
        mismatch_count <= mismatch_count + 1'b1;
      end
    end
  end
`else
  assign mismatch       = 1'b0;
  assign mismatch_count = '0;
`endif

endmodule

// File: tb/tb_alu_result_capture.sv
// Bench for alu_result_capture: queue-based reference model,
// per-cycle compare, directed cases and random traffic.
module tb_alu_result_capture;

  localparam int W = 4;
  localparam int D = 4;
`ifdef ALU_CAPTURE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   in_op = '0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [W-1:0] in_result = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_result;
  logic [3:0]   out_flags;
  logic [2:0]   count;
  logic         mismatch;
  logic [7:0]   mismatch_count;

  alu_result_capture #(.WIDTH(W), .DEPTH(D)) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_result(in_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .count(count), .mismatch(mismatch),
    .mismatch_count(mismatch_count)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    int r;
    int f;
  } ent_t;

  ent_t q[$];
  int   m_cnt = 0;
  bit   m_mis = 0;
  bit   cmp_en = 0;

  function automatic int ref_flags(int op, int a, int b, int r);
    int top;
    int am, bm, rm, c, v;
    top = 1 << (W - 1);
    am = (a & top) != 0;
    bm = (b & top) != 0;
    rm = (r & top) != 0;
    c = 0;
    v = 0;
    if (op == 1) begin
      c = (a + b) >= (1 << W);
      v = (am == bm) && (rm != am);
    end else if (op == 2) begin
      c = a < b;
      v = (am != bm) && (rm != am);
    end
    return ((r == 0) << 3) | (rm << 2) | (c << 1) | v;
  endfunction

  function automatic bit bad_res(int op, int a, int b, int r);
    if (op == 1) return r != ((a + b) % (1 << W));
    if (op == 2) return r != ((a - b + (1 << W)) % (1 << W));
    return 1'b0;
  endfunction

  always @(posedge clock) begin : model
    bit pu, po;
    if (!reset_n || clear) begin
      q.delete();
      m_cnt = 0;
      m_mis = 0;
    end else begin
      pu = in_valid && (q.size() < D);
      po = (q.size() != 0) && out_ready;
      if (po) void'(q.pop_front());
      if (pu) begin
        q.push_back('{r: int'(in_result),
          f: ref_flags(int'(in_op), int'(in_a), int'(in_b),
                       int'(in_result))});
        if (bad_res(int'(in_op), int'(in_a), int'(in_b),
                    int'(in_result))) begin
          m_mis = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
  end

  always @(negedge reset_n) begin
    q.delete();
    m_cnt = 0;
    m_mis = 0;
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("count", count, q.size());
      chk("in_ready", in_ready, q.size() < D);
      chk("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("out_result", out_result, q[0].r);
        chk("out_flags", out_flags, q[0].f);
      end
      chk("mismatch", mismatch, CHK ? m_mis : 1'b0);
      chk("mismatch_count", mismatch_count, CHK ? m_cnt : 0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_tx(input logic v, input logic [3:0] op,
                        input int a, input int b, input int r);
    in_valid  = v;
    in_op     = op;
    in_a      = W'(a);
    in_b      = W'(b);
    in_result = W'(r);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_mismatch", mismatch, 0);
    reset_n = 1'b1;
    cmp_en = 1'b1;
    repeat (3) step();
    chk("idle_count", count, 0);
    chk("idle_out_valid", out_valid, 0);

    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_tx(1, 4'b0001, 10, i, 10 + i);
      step();
      chk("add_res", out_result, 10 + i);
      chk("add_flags", out_flags, 4'b0100);
    end
    in_valid = 1'b0;
    step();
    chk("add_drain", count, 0);

    out_ready = 1'b0;
    set_tx(1, 4'b0010, 10, 3, 7);
    step();
    set_tx(1, 4'b0010, 3, 5, 14);
    step();
    set_tx(1, 4'b0010, 5, 5, 0);
    step();
    in_valid = 1'b0;
    chk("sub_res0", out_result, 4'b0111);
    chk("sub_flags0", out_flags, 4'b0001);
    out_ready = 1'b1;
    step();
    chk("sub_flags1", out_flags, 4'b0110);
    step();
    chk("sub_flags2", out_flags, 4'b1000);
    step();
    out_ready = 1'b0;
    chk("sub_drain", count, 0);

    for (int i = 0; i < 4; i++) begin
      set_tx(1, 4'b0001, i, 1, i + 1);
      step();
    end
    chk("full_count", count, 4);
    chk("full_ready", in_ready, 0);
    set_tx(1, 4'b0001, 4, 1, 5);
    step();
    step();
    chk("full_hold", count, 4);
    out_ready = 1'b1;
    step();
    chk("full_pop", count, 3);
    out_ready = 1'b0;
    step();
    chk("full_accept", count, 4);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("full_order", out_result, i + 1);
      step();
    end
    chk("full_drain", count, 0);
    out_ready = 1'b0;

    set_tx(1, 4'b0001, 1, 1, 2);
    step();
    step();
    chk("pp_pre", count, 2);
    out_ready = 1'b1;
    step();
    chk("pp_count", count, 2);
    out_ready = 1'b0;
    clear = 1'b1;
    step();
    chk("clr_count", count, 0);
    chk("clr_valid", out_valid, 0);
    clear = 1'b0;
    in_valid = 1'b0;
    step();

    set_tx(1, 4'b0001, 7, 1, 9);
    step();
    in_valid = 1'b0;
    chk("bad_mis", mismatch, CHK);
    chk("bad_cnt", mismatch_count, CHK ? 1 : 0);
    chk("bad_stored", out_result, 9);
    set_tx(1, 4'b0001, 1, 1, 2);
    step();
    in_valid = 1'b0;
    chk("sticky_mis", mismatch, CHK);
    out_ready = 1'b1;
    set_tx(1, 4'b0001, 7, 1, 9);
    repeat (300) step();
    in_valid = 1'b0;
    step();
    step();
    chk("sat_cnt", mismatch_count, CHK ? 255 : 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_mis", mismatch, 0);
    chk("clr_mcnt", mismatch_count, 0);

    repeat (2000) begin
      int op, a, b, r;
      case ($urandom_range(0, 3))
        0: op = 1;
        1: op = 2;
        default: op = $urandom_range(0, 15);
      endcase
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) r = $urandom_range(0, 15);
      else if (op == 1) r = (a + b) & 15;
      else if (op == 2) r = (a - b) & 15;
      else r = $urandom_range(0, 15);
      set_tx($urandom_range(0, 3) != 0, 4'(op), a, b, r);
      out_ready = $urandom_range(0, 2) != 0;
      clear = $urandom_range(0, 96) == 0;
      step();
    end
    clear = 1'b0;

    out_ready = 1'b0;
    set_tx(1, 4'b0001, 7, 1, 9);
    repeat (3) step();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_mis", mismatch, 0);
    in_valid = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (3) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_result_capture.md
# alu_result_capture

Consumer side of the add/subtract datapath: accepts one ALU transaction per handshake (opcode, both operands, result), derives status flags, and buffers the entries in a small FIFO. A downstream reader drains that FIFO, such as a register-file writeback, a flag register or a bench scoreboard. It is the reader counterpart to the stimulus/driver side that presents operands and samples the ALU output.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- DEPTH, 4, FIFO entries; power of two, ≥2
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush of FIFO, flags and check state
- in_valid  input  1  transaction present
- in_ready  output  1  capture can accept
- in_op  input  4  4'b0001 = add, 4'b0010 = subtract, other = pass
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_result  input  WIDTH  result produced by the ALU
- out_valid  output  1  head entry available
- out_ready  input  1  reader accepts head
- out_result  output  WIDTH  head result
- out_flags  output  4  head flags {Z,N,C,V}
- count  output  $clog2(DEPTH)+1  occupied entries
- mismatch  output  1  sticky result-check failure
- mismatch_count  output  8  saturating failure count

## Operation
- Push when in_valid && in_ready; pop when out_valid && out_ready; both may occur in one cycle (count unchanged).
- in_ready = (count < DEPTH). A pop in the same cycle does not raise in_ready; there is no full pass-through.
- out_valid = (count != 0); out_result/out_flags come from the head register, first-word-fall-through.
- Read/write pointers wrap modulo DEPTH.
- Flags are computed from the inputs at push time and stored with the result:
  - Z = (in_result == 0)
  - N = in_result[WIDTH-1]
  - add: C = carry out of in_a+in_b (WIDTH+1-bit sum); V = (a_msb==b_msb) && (r_msb!=a_msb)
  - subtract: C = borrow (in_a < in_b, unsigned); V = (a_msb!=b_msb) && (r_msb!=a_msb)
  - other op: C = V = 0
- clear: count←0, pointers←0, mismatch←0, mismatch_count←0. clear has priority over a simultaneous push/pop, which are dropped.
- Stored data is not reset; only pointers, count and check state are reset.

## Timing
- Reset values (asynchronous, while reset_n=0):
  - in_ready=1, out_valid=0, count=0, mismatch=0, mismatch_count=0
  - out_result/out_flags undefined-don't-care while out_valid=0
- Push-to-out_valid latency: 1 clock (entry visible the cycle after the accepting edge when the FIFO was empty).
- Pop takes effect at the edge; the next entry is on out_result in the following cycle.
- Full: in_ready=0. in_valid is ignored and the upstream must hold its transaction.
- Empty: out_ready is ignored and count does not underflow.
- Reset asserted mid-operation discards all buffered entries; the outputs return to their reset values immediately.

## Configuration
- ALU_CAPTURE_CHECK_EN defined:
  - On each push, recompute the expected result: add → (in_a+in_b) mod 2^WIDTH, subtract → (in_a−in_b) mod 2^WIDTH, other op → no check.
  - On a differing in_result, set mismatch (sticky until clear/reset) and increment mismatch_count, saturating at 255.
  - The entry is still stored.
- Not defined: no comparator is built; mismatch and mismatch_count are tied to 0. Ports are unchanged.

## Test plan
- Reset then idle: reset_n low 2 cycles → in_ready=1, out_valid=0, count=0; after release no change without in_valid.
- Add sweep: in_a=4'b1010, op=4'b0001, in_b=0000..0011 with correct results 1010,1011,1100,1101, out_ready=1 → four entries in order, flags 4'b0100 each (N=1, C=0, V=0).
- Subtract flags: 1010−0011, result 0111 → flags 4'b0001 (V=1); 0011−0101, result 1110 → flags 4'b0110 (N=1, C=1); 0101−0101, result 0000 → 4'b1000.
- Full/backpressure: out_ready=0, push 5 transactions → count=4 and in_ready=0 after the 4th; the 5th is held until one pop, then accepted. Pops return FIFO order and pointer wrap is verified.
- Simultaneous push+pop at count=2 → count stays 2. clear together with a push → count=0 and the push is dropped.
- With ALU_CAPTURE_CHECK_EN: add 0111+0001 with in_result=1001 → mismatch=1, mismatch_count=1, entry still stored. A correct push afterwards leaves mismatch=1. 300 bad pushes → count saturates at 255. Without the macro, the same stimulus gives mismatch=0.
